// File: rtl/inv_round_key_gen.sv
// Reverse AES-128 key schedule: loads the round-10 key and emits round keys
// 10 down to 0, one per clock, for the inverse-cipher AddRoundKey stage.
module inv_round_key_gen #(
   parameter int KEY_L = 128,
   parameter int WORD  = 32,
   parameter int NR    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [KEY_L-1:0] key,
   output logic             ready,
   output logic [KEY_L-1:0] round_key,
   output logic [3:0]       round_idx,
   output logic             valid_out,
   output logic             last_out
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [3:0] NR_4   = 4'(NR);

   // Forward AES S-box; entry 0 is the most significant byte of the literal.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [0:0]       state_q, state_d;
   logic [KEY_L-1:0] work_q, work_d;
   logic [KEY_L-1:0] rk_q, rk_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       idx_q, idx_d;
   logic             vld_q, vld_d;
   logic             last_q, last_d;

   logic [WORD-1:0] w0, w1, w2, w3;
   logic [WORD-1:0] p0, p1, p2, p3;
   logic [WORD-1:0] rot_p3, sub_p3;

   assign {w0, w1, w2, w3} = work_q;
   assign p3     = w3 ^ w2;
   assign p2     = w2 ^ w1;
   assign p1     = w1 ^ w0;
   assign rot_p3 = {p3[WORD-9:0], p3[WORD-1:WORD-8]};

   for (genvar b = 0; b < 4; b++) begin : g_sub
      assign sub_p3[8*b +: 8] = sbox(rot_p3[8*b +: 8]);
   end

   // The step taken at cnt==0 produces garbage (rcon 0); it is never emitted.
   assign p0 = w0 ^ sub_p3 ^ {rcon(cnt_q), {(WORD-8){1'b0}}};

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      rk_d    = rk_q;
      idx_d   = idx_q;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               work_d  = key;
               cnt_d   = NR_4;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            rk_d   = work_q;
            idx_d  = cnt_q;
            vld_d  = 1'b1;
            work_d = {p0, p1, p2, p3};
            if (cnt_q == 4'd0) begin
               last_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         rk_q    <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         rk_q    <= rk_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign round_key = rk_q;
   assign round_idx = idx_q;
   assign valid_out = vld_q;
   assign last_out  = last_q;

endmodule
